// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state codes, default field widths and
// the NOP control word.
package pipe_pkg;

    typedef logic [1:0] state_t;

    localparam state_t EMPTY    = 2'd0;
    localparam state_t FULL     = 2'd1;
    localparam state_t SKIDFULL = 2'd2;

    localparam int unsigned CTRL_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 133;

    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stage's bubble/stall performance readout.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc && (count_q != '1)) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline stage: valid/ready handshake, optional 2-entry skid buffer, flush, and
// saturating bubble/stall counters. Control is forced to NOP whenever the head is empty.
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = CTRL_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] main_data_q, skid_data_q;
    logic              in_xfer, out_xfer;
    logic              load_main_in, load_main_skid, load_skid;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:    if (in_xfer) state_d = FULL;
            FULL: begin
                if (out_xfer && !in_xfer) begin
                    state_d = EMPTY;
                end else if (in_xfer && !out_xfer) begin
                    state_d = SKIDFULL;
                end
            end
            SKIDFULL: if (out_xfer) state_d = FULL;
            default:  state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        case (state_q)
            FULL:     occupancy = 2'd1;
            SKIDFULL: occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
        // With the skid buffer, in_ready depends only on state so it can be registered upstream.
        if (SKID != 0) begin
            in_ready = (state_q != SKIDFULL) & ~flush & ~reset;
        end else begin
            in_ready = ((state_q == EMPTY) | out_ready) & ~flush & ~reset;
        end
        out_ctrl = (state_q != EMPTY) ? main_ctrl_q : CTRL_W'(NOP_CTRL);
        out_data = main_data_q;
    end

    // in_xfer is already gated by flush; only the skid-to-main move needs its own gate.
    assign load_main_in   = in_xfer & ((state_q == EMPTY) | ((state_q == FULL) & out_xfer));
    assign load_skid      = in_xfer & (state_q == FULL) & ~out_xfer;
    assign load_main_skid = out_xfer & (state_q == SKIDFULL) & ~flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl_q <= in_ctrl;
                main_data_q <= in_data;
            end else if (load_main_skid) begin
                main_ctrl_q <= skid_ctrl_q;
                main_data_q <= skid_data_q;
            end
            if (load_skid) begin
                skid_ctrl_q <= in_ctrl;
                skid_data_q <= in_data;
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_bubble_cnt (
        .clock(clock),
        .reset(reset),
        .clear(1'b0),
        .inc  (~out_valid),
        .count(bubble_cnt)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clock(clock),
        .reset(reset),
        .clear(1'b0),
        .inc  (out_valid & ~out_ready),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Scoreboard bench for pipe_stage_elastic: a skid instance and a SKID=0/CNT_W=4 instance are
// driven with directed and random traffic and checked against a queue-based reference model.
module tb_pipe_stage_elastic;
    import pipe_pkg::*;

    typedef struct packed {
        logic [9:0]   c;
        logic [132:0] d;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic         iv [2];
    logic         orr[2];
    logic         fl [2];
    logic [9:0]   ic [2];
    logic [132:0] id [2];

    logic         ir0, ov0, ir1, ov1;
    logic [1:0]   occ0, occ1;
    logic [9:0]   oc0, oc1;
    logic [132:0] od0, od1;
    logic [15:0]  bc0, sc0;
    logic [3:0]   bc1, sc1;

    pipe_stage_elastic #(.CTRL_W(10), .DATA_W(133), .SKID(1), .CNT_W(16)) dut0 (
        .clock(clock), .reset(reset), .flush(fl[0]), .in_valid(iv[0]), .in_ready(ir0),
        .in_ctrl(ic[0]), .in_data(id[0]), .out_valid(ov0), .out_ready(orr[0]),
        .out_ctrl(oc0), .out_data(od0), .occupancy(occ0), .bubble_cnt(bc0), .stall_cnt(sc0)
    );

    pipe_stage_elastic #(.CTRL_W(10), .DATA_W(133), .SKID(0), .CNT_W(4)) dut1 (
        .clock(clock), .reset(reset), .flush(fl[1]), .in_valid(iv[1]), .in_ready(ir1),
        .in_ctrl(ic[1]), .in_data(id[1]), .out_valid(ov1), .out_ready(orr[1]),
        .out_ctrl(oc1), .out_data(od1), .occupancy(occ1), .bubble_cnt(bc1), .stall_cnt(sc1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-instance FIFO of accepted entries, capacity 2 (skid) or 1.
    ent_t         mq[2][$];
    logic         exp_rdy[2] = '{1'b0, 1'b0};
    int           bcm[2]     = '{0, 0};
    int           scm[2]     = '{0, 0};
    logic [132:0] lastd[2];
    int           cmax[2]    = '{65535, 15};
    int           cap[2]     = '{2, 1};

    task automatic chk(input string nm, input logic [132:0] act, input logic [132:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [132:0] rnd_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[132:0];
    endfunction

    // Push side: accept on the edge if the model says the stage is ready; flush empties all.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mq[0].delete();
            mq[1].delete();
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (fl[i]) begin
                    mq[i].delete();
                end else if (iv[i] && exp_rdy[i]) begin
                    mq[i].push_back('{c: ic[i], d: id[i]});
                end
            end
        end
    end

    // Monitor: compare outputs mid-cycle against the model, pop on a downstream transfer.
    always @(negedge clock) begin
        int           sz;
        ent_t         head;
        logic         a_ir, a_ov;
        logic [1:0]   a_occ;
        logic [9:0]   a_oc;
        logic [132:0] a_od;
        logic [15:0]  a_bc, a_sc;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                bcm[i]     = 0;
                scm[i]     = 0;
                exp_rdy[i] = 1'b0;
                lastd[i]   = '0;
            end else begin
                if (i == 0) begin
                    a_ir = ir0; a_ov = ov0; a_occ = occ0; a_oc = oc0; a_od = od0;
                    a_bc = bc0; a_sc = sc0;
                end else begin
                    a_ir = ir1; a_ov = ov1; a_occ = occ1; a_oc = oc1; a_od = od1;
                    a_bc = {12'd0, bc1}; a_sc = {12'd0, sc1};
                end
                sz = mq[i].size();
                exp_rdy[i] = ((cap[i] == 2) ? (sz < 2) : (sz == 0 || orr[i])) && !fl[i];
                chk($sformatf("dut%0d in_ready", i), a_ir, exp_rdy[i]);
                chk($sformatf("dut%0d out_valid", i), a_ov, sz != 0);
                chk($sformatf("dut%0d occupancy", i), a_occ, sz);
                chk($sformatf("dut%0d bubble_cnt", i), a_bc, bcm[i]);
                chk($sformatf("dut%0d stall_cnt", i), a_sc, scm[i]);
                if (sz == 0) begin
                    chk($sformatf("dut%0d out_ctrl nop", i), a_oc, NOP_CTRL);
                    chk($sformatf("dut%0d out_data hold", i), a_od, lastd[i]);
                end else begin
                    head = mq[i][0];
                    chk($sformatf("dut%0d out_ctrl", i), a_oc, head.c);
                    chk($sformatf("dut%0d out_data", i), a_od, head.d);
                    lastd[i] = head.d;
                    if (orr[i]) void'(mq[i].pop_front());
                end
                if (sz == 0 && bcm[i] < cmax[i]) bcm[i]++;
                if (sz != 0 && !orr[i] && scm[i] < cmax[i]) scm[i]++;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push0(input logic [9:0] c);
        iv[0] = 1'b1;
        ic[0] = c;
        id[0] = rnd_data();
    endtask

    int pv_tab[4] = '{90, 50, 100, 30};
    int pr_tab[4] = '{90, 40, 20, 100};
    int bsave;

    initial begin
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; orr[i] = 1'b1; fl[i] = 1'b0; ic[i] = '0; id[i] = '0;
        end
        repeat (3) cyc();
        reset = 1'b0;

        // dut1 idles 20 cycles, then one entry stalls for 20 cycles: both counters saturate.
        orr[1] = 1'b0;
        repeat (20) cyc();
        chk("t6 bubble saturated", bc1, 15);
        iv[1] = 1'b1; ic[1] = 10'h155; id[1] = rnd_data();
        cyc();
        iv[1] = 1'b0;
        repeat (20) cyc();
        chk("t6 stall saturated", sc1, 15);
        orr[1] = 1'b1;
        cyc();

        // Full-throughput stream of ctrl 1..8 into dut0.
        bsave = bc0;
        for (int k = 1; k <= 8; k++) begin
            push0(10'(k));
            cyc();
        end
        iv[0] = 1'b0;
        cyc();
        chk("t2 bubble grew by one", bc0, bsave + 1);

        // Backpressure: A and B land in main and skid, then drain in order.
        orr[0] = 1'b0;
        push0(10'h0A1);
        cyc();
        push0(10'h0B2);
        cyc();
        iv[0] = 1'b0;
        cyc();
        chk("t3 occupancy two", occ0, 2);
        chk("t3 in_ready low", ir0, 0);
        chk("t3 head is A", oc0, 10'h0A1);
        orr[0] = 1'b1;
        cyc();
        chk("t3 head is B", oc0, 10'h0B2);
        cyc();
        chk("t3 drained", ov0, 0);

        // Asynchronous reset while dut0 holds two entries.
        orr[0] = 1'b0;
        push0(10'h111);
        cyc();
        push0(10'h222);
        cyc();
        iv[0] = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("t1 out_valid", ov0, 0);
        chk("t1 out_ctrl", oc0, 0);
        chk("t1 occupancy", occ0, 0);
        chk("t1 bubble_cnt", bc0, 0);
        chk("t1 stall_cnt", sc0, 0);
        chk("t1 in_ready", ir0, 0);
        chk("t1 dut1 in_ready", ir1, 0);
        cyc();
        reset = 1'b0;
        cyc();

        // Flush in SKIDFULL with a concurrent input; nothing may come out afterwards.
        push0(10'h301);
        cyc();
        push0(10'h302);
        cyc();
        push0(10'h3FF);
        fl[0] = 1'b1;
        cyc();
        fl[0] = 1'b0;
        iv[0] = 1'b0;
        chk("t4 out_valid", ov0, 0);
        chk("t4 out_ctrl", oc0, 0);
        chk("t4 occupancy", occ0, 0);
        orr[0] = 1'b1;
        repeat (3) cyc();

        // Random traffic on both instances.
        for (int seg = 0; seg < 4; seg++) begin
            repeat (600) begin
                for (int i = 0; i < 2; i++) begin
                    iv[i]  = ($urandom_range(0, 99) < pv_tab[seg]);
                    orr[i] = ($urandom_range(0, 99) < pr_tab[seg]);
                    fl[i]  = ($urandom_range(0, 99) < 3);
                    ic[i]  = 10'($urandom);
                    id[i]  = rnd_data();
                end
                cyc();
            end
        end
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; fl[i] = 1'b0; orr[i] = 1'b1;
        end
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
